// File: rtl/uart_link_pkg.sv
// Shared definitions for the acquisition UART link (command receiver and waveform sender).
package uart_link_pkg;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_ACQUIRE   = 8'h01;
  localparam logic [7:0] OP_THRESHOLD = 8'h02;
  localparam logic [7:0] OP_DELAY     = 8'h03;

  localparam int PKT_BYTES = 3;

  typedef enum logic [1:0] {
    ACQ_IDLE = 2'b00,
    ACQ_RAW  = 2'b01,
    ACQ_FIR  = 2'b10,
    ACQ_RSVD = 2'b11
  } acq_mode_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampling 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, framing check.
//  state    | meaning
//  RX_IDLE  | line idle, waiting for synchronised rx to go low
//  RX_START | half a bit into the start bit, confirm it is still low
//  RX_DATA  | sample 8 data bits mid-bit, LSB first
//  RX_STOP  | sample stop bit; high -> byte_valid, low -> frame_err
//  RX_BREAK | line held low after a framing error, wait for it to return high
module uart_rx_byte
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta;
  logic          rx_sync;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
              state      <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          if (rx_sync) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_receiver.sv
// PC->FPGA command receiver: assembles [opcode][data_hi][data_lo] packets and
// updates the acquisition control registers.
module uart_cmd_receiver
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_CLKS = 768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [1:0]  acquire,
  output logic [13:0] threshold,
  output logic [15:0] trig_delay,
  output logic        cmd_strobe,
  output logic [7:0]  cmd_opcode,
  output logic        frame_err,
  output logic        cmd_err,
  output logic        pkt_timeout
);

  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [1:0]    IDX_LAST = 2'(PKT_BYTES - 1);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [1:0]    idx;
  logic [7:0]    op_byte;
  logic [7:0]    hi_byte;
  logic [TW-1:0] tmr;
  logic [15:0]   pkt_data;
  acq_mode_t     acq_q;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // The last byte is decoded straight off the receiver output, so registers
  // update one clock after its byte_valid.
  assign pkt_data = {hi_byte, byte_data};
  assign acquire  = acq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      op_byte     <= '0;
      hi_byte     <= '0;
      tmr         <= '0;
      acq_q       <= ACQ_IDLE;
      threshold   <= '0;
      trig_delay  <= '0;
      cmd_opcode  <= '0;
      cmd_strobe  <= 1'b0;
      cmd_err     <= 1'b0;
      pkt_timeout <= 1'b0;
    end else begin
      cmd_strobe  <= 1'b0;
      cmd_err     <= 1'b0;
      pkt_timeout <= 1'b0;
      if (frame_err) begin
        idx <= '0;
        tmr <= '0;
      end else if (byte_valid) begin
        tmr <= '0;
        if (idx == 2'd0) begin
          op_byte <= byte_data;
          idx     <= 2'd1;
        end else if (idx != IDX_LAST) begin
          hi_byte <= byte_data;
          idx     <= idx + 2'd1;
        end else begin
          idx <= '0;
          case (op_byte)
            OP_NOP: begin
              cmd_strobe <= 1'b1;
              cmd_opcode <= op_byte;
            end
            OP_ACQUIRE: begin
              if (pkt_data[1:0] == ACQ_RSVD) begin
                cmd_err <= 1'b1;
              end else begin
                acq_q      <= acq_mode_t'(pkt_data[1:0]);
                cmd_strobe <= 1'b1;
                cmd_opcode <= op_byte;
              end
            end
            OP_THRESHOLD: begin
              threshold  <= pkt_data[13:0];
              cmd_strobe <= 1'b1;
              cmd_opcode <= op_byte;
            end
            OP_DELAY: begin
              trig_delay <= pkt_data;
              cmd_strobe <= 1'b1;
              cmd_opcode <= op_byte;
            end
            default: cmd_err <= 1'b1;
          endcase
        end
      end else if (idx != 2'd0) begin
        if (tmr == TMR_LAST) begin
          idx         <= '0;
          tmr         <= '0;
          pkt_timeout <= 1'b1;
        end else begin
          tmr <= tmr + 1'b1;
        end
      end else begin
        tmr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Self-checking bench for uart_cmd_receiver: serial stimulus with a scoreboard of
// expected decode results popped whenever the DUT pulses cmd_strobe or cmd_err.
module tb_uart_cmd_receiver;

  localparam int CPB     = 16;
  localparam int TIMEOUT = 768;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic [1:0]  acquire;
  logic [13:0] threshold;
  logic [15:0] trig_delay;
  logic        cmd_strobe;
  logic [7:0]  cmd_opcode;
  logic        frame_err;
  logic        cmd_err;
  logic        pkt_timeout;

  uart_cmd_receiver #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .acquire    (acquire),
    .threshold  (threshold),
    .trig_delay (trig_delay),
    .cmd_strobe (cmd_strobe),
    .cmd_opcode (cmd_opcode),
    .frame_err  (frame_err),
    .cmd_err    (cmd_err),
    .pkt_timeout(pkt_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [7:0]  op;
    logic [1:0]  acq;
    logic [13:0] thr;
    logic [15:0] dly;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bv_count = 0, fe_count = 0, to_count = 0, st_count = 0, ce_count = 0;
  int last_bv_cyc = 0, last_to_cyc = 0;

  logic [1:0]  m_acq;
  logic [13:0] m_thr;
  logic [15:0] m_dly;
  logic [7:0]  m_op;

  task automatic monitor_outputs();
    logic prev_s = 1'b0, prev_e = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_s = 1'b0;
        prev_e = 1'b0;
        continue;
      end
      if (dut.u_rx.byte_valid) begin
        bv_count++;
        last_bv_cyc = cyc;
      end
      if (frame_err) fe_count++;
      if (pkt_timeout) begin
        to_count++;
        last_to_cyc = cyc;
      end
      if (cmd_strobe) st_count++;
      if (cmd_err) ce_count++;
      if (cmd_strobe || cmd_err) begin
        checks++;
        if ((cmd_strobe && cmd_err) || (cmd_strobe && prev_s) || (cmd_err && prev_e)) begin
          errors++;
          $display("FAIL pulse_shape: strobe=%0b err=%0b prev_strobe=%0b prev_err=%0b, required single 1-clk pulse",
                   cmd_strobe, cmd_err, prev_s, prev_e);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: strobe=%0b err=%0b opcode=%02h, required no pulse",
                   cmd_strobe, cmd_err, cmd_opcode);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (cmd_err !== e.is_err) begin
            errors++;
            $display("FAIL cmd_kind: cmd_err=%0b, required %0b", cmd_err, e.is_err);
          end
          checks++;
          if (cyc - last_bv_cyc != 1) begin
            errors++;
            $display("FAIL decode_latency: %0d clks after byte_valid, required 1", cyc - last_bv_cyc);
          end
          checks++;
          if ({cmd_opcode, acquire, threshold, trig_delay} !== {e.op, e.acq, e.thr, e.dly}) begin
            errors++;
            $display("FAIL regs: op=%02h acq=%0b thr=%04h dly=%04h, required op=%02h acq=%0b thr=%04h dly=%04h",
                     cmd_opcode, acquire, threshold, trig_delay, e.op, e.acq, e.thr, e.dly);
          end
        end
      end
      prev_s = cmd_strobe;
      prev_e = cmd_err;
    end
  endtask

  task automatic model_reset();
    m_acq = 2'b00;
    m_thr = '0;
    m_dly = '0;
    m_op  = '0;
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    if (stop_ok) send_bit(1'b1);
  endtask

  task automatic send_packet(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo);
    exp_t e;
    logic [15:0] d;
    d = {hi, lo};
    e.is_err = 1'b0;
    case (op)
      8'h00: ;
      8'h01: if (d[1:0] == 2'b11) e.is_err = 1'b1; else m_acq = d[1:0];
      8'h02: m_thr = d[13:0];
      8'h03: m_dly = d;
      default: e.is_err = 1'b1;
    endcase
    if (!e.is_err) m_op = op;
    e.op  = m_op;
    e.acq = m_acq;
    e.thr = m_thr;
    e.dly = m_dly;
    exp_q.push_back(e);
    send_byte(op, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    checks++;
    if ({acquire, threshold, trig_delay, cmd_opcode, cmd_strobe, frame_err, cmd_err, pkt_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_values: acq=%0b thr=%04h dly=%04h op=%02h pulses=%b%b%b%b, required all zero",
               acquire, threshold, trig_delay, cmd_opcode, cmd_strobe, frame_err, cmd_err, pkt_timeout);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_acquire();
    int st0 = st_count;
    send_packet(8'h01, 8'h00, 8'h02);
    wait_drained();
    checks++;
    if (exp_q.size() != 0 || st_count != st0 + 1) begin
      errors++;
      $display("FAIL acquire_strobe: pending=%0d strobes=%0d, required 0 pending and 1 strobe",
               exp_q.size(), st_count - st0);
    end
    checks++;
    if (acquire !== 2'b10 || cmd_opcode !== 8'h01) begin
      errors++;
      $display("FAIL acquire_value: acq=%0b op=%02h, required acq=10 op=01", acquire, cmd_opcode);
    end
  endtask

  task automatic test_threshold_delay();
    send_packet(8'h02, 8'hFF, 8'hFF);
    wait_drained();
    checks++;
    if (threshold !== 14'h3FFF) begin
      errors++;
      $display("FAIL threshold: got %04h, required 3fff", threshold);
    end
    send_packet(8'h03, 8'h12, 8'h34);
    wait_drained();
    checks++;
    if (trig_delay !== 16'h1234 || threshold !== 14'h3FFF) begin
      errors++;
      $display("FAIL delay: dly=%04h thr=%04h, required dly=1234 thr=3fff", trig_delay, threshold);
    end
  endtask

  task automatic test_cmd_err();
    int st0 = st_count;
    int ce0 = ce_count;
    send_packet(8'h05, 8'h00, 8'h00);
    send_packet(8'h01, 8'h00, 8'h03);
    wait_drained();
    checks++;
    if (ce_count != ce0 + 2 || st_count != st0) begin
      errors++;
      $display("FAIL cmd_err_count: errs=%0d strobes=%0d, required errs=2 strobes=0",
               ce_count - ce0, st_count - st0);
    end
    checks++;
    if (acquire !== 2'b10 || cmd_opcode !== 8'h03) begin
      errors++;
      $display("FAIL cmd_err_regs: acq=%0b op=%02h, required acq=10 op=03", acquire, cmd_opcode);
    end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_count;
    int to0 = to_count;
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b0);
    uart_rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if (fe_count != fe0 + 1 || to_count != to0) begin
      errors++;
      $display("FAIL frame_err: frame_errs=%0d timeouts=%0d, required 1 and 0", fe_count - fe0, to_count - to0);
    end
    send_packet(8'h01, 8'h00, 8'h01);
    wait_drained();
    checks++;
    if (acquire !== 2'b01 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_recover: acq=%0b pending=%0d, required acq=01 pending=0", acquire, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int to0 = to_count;
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < TIMEOUT + 200 && to_count == to0; i++) @(negedge clk);
    checks++;
    if (to_count != to0 + 1) begin
      errors++;
      $display("FAIL pkt_timeout: pulses=%0d, required 1", to_count - to0);
    end else begin
      checks++;
      if (last_to_cyc - last_bv_cyc != TIMEOUT + 1) begin
        errors++;
        $display("FAIL timeout_delay: %0d clks after byte_valid, required %0d",
                 last_to_cyc - last_bv_cyc, TIMEOUT + 1);
      end
    end
    send_packet(8'h01, 8'h00, 8'h02);
    wait_drained();
    checks++;
    if (acquire !== 2'b10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_realign: acq=%0b pending=%0d, required acq=10 pending=0", acquire, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int st0 = st_count;
    send_packet(8'h02, 8'h00, 8'h55);
    send_packet(8'h00, 8'hFF, 8'hFF);
    wait_drained();
    checks++;
    if (st_count != st0 + 2 || cmd_opcode !== 8'h00 || threshold !== 14'h0055) begin
      errors++;
      $display("FAIL back_to_back: strobes=%0d op=%02h thr=%04h, required 2 op=00 thr=0055",
               st_count - st0, cmd_opcode, threshold);
    end
  endtask

  task automatic test_glitch_reset();
    int bv0 = bv_count;
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (bv_count != bv0) begin
      errors++;
      $display("FAIL glitch: bytes=%0d, required 0", bv_count - bv0);
    end
    send_byte(8'h01, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({acquire, threshold, trig_delay, cmd_opcode, cmd_strobe, frame_err, cmd_err, pkt_timeout} !== '0) begin
      errors++;
      $display("FAIL midpacket_reset: acq=%0b thr=%04h dly=%04h op=%02h, required all zero",
               acquire, threshold, trig_delay, cmd_opcode);
    end
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_packet(8'h03, 8'hAB, 8'hCD);
    wait_drained();
    checks++;
    if (trig_delay !== 16'hABCD || acquire !== 2'b00 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_packet: dly=%04h acq=%0b pending=%0d, required dly=abcd acq=00 pending=0",
               trig_delay, acquire, exp_q.size());
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    fork
      monitor_outputs();
    join_none
    test_reset();
    test_acquire();
    test_threshold_delay();
    test_cmd_err();
    test_frame_err();
    test_timeout();
    test_back_to_back();
    test_glitch_reset();
    repeat (50) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: pending=%0d, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
